uart_cmd_parser: RTL and testbench
==================================

Name: uart_cmd_parser

Overview:
Sits directly downstream of the UART receiver and consumes its byte stream (rx_data / rx_data_vld). It assembles fixed-format 7-byte command frames, verifies a checksum, and presents each valid command on a valid/ready interface. Consumers are the bench-side register and SCCB configuration writers. It also detects inter-byte timeout, checksum error and output overflow.

Parameters:
TIMEOUT_CYC, 43400, sclk cycles allowed between bytes inside a frame (10 byte times at 434 clk/bit); counter width 16 bits.
HDR0, 8'h55, first header byte.
HDR1, 8'hAA, second header byte.

Ports:
sclk  in  1  system clock
s_rst  in  1  synchronous reset, active-high
rx_data  in  8  received byte from UART receiver
rx_data_vld  in  1  one-cycle strobe, rx_data valid
cmd_vld  out  1  command available; held until accepted
cmd_rdy  in  1  consumer accepts when cmd_vld & cmd_rdy
cmd_op  out  8  command opcode
cmd_addr  out  16  address {addr_h, addr_l}
cmd_data  out  8  data byte
err_csum  out  1  one-cycle pulse, checksum mismatch
err_tout  out  1  one-cycle pulse, inter-byte timeout
err_ovf  out  1  one-cycle pulse, good frame dropped because cmd_vld still pending
busy  out  1  high when state != IDLE

Behaviour:
- Reset (s_rst high at sclk edge) clears all outputs and registers to 0 and sets state to IDLE. This applies mid-frame and while cmd_vld is pending; a pending command is discarded.
- Frame format: HDR0, HDR1, OP, ADDR_H, ADDR_L, DATA, CSUM. CSUM = (OP+ADDR_H+ADDR_L+DATA) mod 256, computed as an 8-bit wrapping accumulator.
- The FSM advances only on rx_data_vld:
  - IDLE: byte==HDR0 -> H1; any other byte stays in IDLE.
  - H1: byte==HDR1 -> OP; byte==HDR0 stays in H1; any other byte -> IDLE.
  - OP: store op, acc=byte -> AH.
  - AH: store, acc+=byte -> AL.
  - AL: store, acc+=byte -> DT.
  - DT: store, acc+=byte -> CS.
  - CS: compare byte with acc, then -> IDLE.
- Header bytes are not checked for payload value. 0x55 or 0xAA appearing in the payload is ordinary data.
- CS compare equal and cmd_vld==0 (or being accepted in the same cycle): load cmd_op/cmd_addr/cmd_data and set cmd_vld=1 on the next edge. Latency is 1 cycle after the CSUM strobe.
- CS compare equal and cmd_vld==1 with cmd_rdy==0: the output regs are unchanged, and err_ovf pulses 1 cycle after the CSUM strobe.
- CS mismatch: err_csum pulses 1 cycle after the CSUM strobe; there is no output update.
- cmd_vld & cmd_rdy at an edge: cmd_vld drops the next cycle unless a new frame loads in that same edge, in which case cmd_vld stays 1 with the new contents. Output fields are stable whenever cmd_vld=1 and not accepted.
- Timeout: the counter is cleared on every rx_data_vld and in IDLE, and increments otherwise. When it reaches TIMEOUT_CYC-1 in a non-IDLE state: state -> IDLE, err_tout pulses 1 cycle, counter clears. If rx_data_vld arrives in the same cycle, the byte wins and no timeout occurs.
- Error pulses are mutually exclusive per frame, with at most one per cycle.
- busy is registered and equals (state != IDLE).

Test Plan:
- Good frame: 55 AA 01 12 34 5A A1 with cmd_rdy=1 -> cmd_vld for 1 cycle, 1 clk after the last strobe, with op=01, addr=1234, data=5A; no error pulses.
- Bad checksum: 55 AA 01 12 34 5A A2 -> err_csum single pulse; cmd_vld stays 0; busy returns to 0.
- Header resync and wrap: 55 55 AA 80 80 80 80 80 (sum 0x200 wraps to 00, so the frame needs a trailing CSUM byte 00). Send 55 55 AA 80 80 80 80 00 -> cmd_vld with op=80, addr=8080, data=80.
- Timeout: 55 AA 01, then idle for TIMEOUT_CYC cycles -> err_tout pulse, busy=0. A fresh good frame afterwards is accepted normally.
- Backpressure/overflow: with cmd_rdy=0, send two good frames (op 01 then op 02) -> the first is held (op=01 stable), err_ovf pulses at the end of the second. Raise cmd_rdy -> cmd_vld drops next cycle.
- Reset mid-frame: s_rst high after 55 AA 01 12 -> all outputs 0, state IDLE. The trailing 34 5A A1 bytes produce no cmd_vld and no error pulse.

Source files
------------

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser
//   Assembles 7-byte command frames (HDR0 HDR1 OP ADDR_H ADDR_L DATA CSUM)
//   from the UART receiver byte stream, verifies the 8-bit additive checksum
//   over OP..DATA and presents good commands on a valid/ready interface.
//   Flags checksum errors, inter-byte timeouts and commands dropped because
//   the previous one was still pending.
// Ports
//   sclk, s_rst            clock, synchronous active-high reset
//   rx_data, rx_data_vld   byte stream from the UART receiver (1-cycle strobe)
//   cmd_vld, cmd_rdy       command handshake; cmd_vld held until accepted
//   cmd_op/addr/data       command fields, stable while cmd_vld is pending
//   err_csum/tout/ovf      one-cycle error pulses
//   busy                   registered (state != IDLE)
module uart_cmd_parser #(
  parameter int          TIMEOUT_CYC = 43400,
  parameter logic [7:0]  HDR0        = 8'h55,
  parameter logic [7:0]  HDR1        = 8'hAA
) (
  input  logic        sclk,
  input  logic        s_rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_data_vld,
  output logic        cmd_vld,
  input  logic        cmd_rdy,
  output logic [7:0]  cmd_op,
  output logic [15:0] cmd_addr,
  output logic [7:0]  cmd_data,
  output logic        err_csum,
  output logic        err_tout,
  output logic        err_ovf,
  output logic        busy
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {IDLE, H1, OP, AH, AL, DT, CS} state_t;

  state_t      state, state_nxt;
  logic [7:0]  acc, acc_nxt;
  logic [7:0]  f_op, f_op_nxt, f_ah, f_ah_nxt, f_al, f_al_nxt, f_dt, f_dt_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic        cmd_vld_nxt;
  logic [7:0]  cmd_op_nxt, cmd_data_nxt;
  logic [15:0] cmd_addr_nxt;
  logic        err_csum_nxt, err_tout_nxt, err_ovf_nxt;

  always_ff @(posedge sclk) begin
    if (s_rst) begin
      state    <= IDLE;
      acc      <= '0;
      f_op     <= '0;
      f_ah     <= '0;
      f_al     <= '0;
      f_dt     <= '0;
      cnt      <= '0;
      cmd_vld  <= 1'b0;
      cmd_op   <= '0;
      cmd_addr <= '0;
      cmd_data <= '0;
      err_csum <= 1'b0;
      err_tout <= 1'b0;
      err_ovf  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      acc      <= acc_nxt;
      f_op     <= f_op_nxt;
      f_ah     <= f_ah_nxt;
      f_al     <= f_al_nxt;
      f_dt     <= f_dt_nxt;
      cnt      <= cnt_nxt;
      cmd_vld  <= cmd_vld_nxt;
      cmd_op   <= cmd_op_nxt;
      cmd_addr <= cmd_addr_nxt;
      cmd_data <= cmd_data_nxt;
      err_csum <= err_csum_nxt;
      err_tout <= err_tout_nxt;
      err_ovf  <= err_ovf_nxt;
      busy     <= (state_nxt != IDLE);
    end
  end

  always_comb begin
    state_nxt    = state;
    acc_nxt      = acc;
    f_op_nxt     = f_op;
    f_ah_nxt     = f_ah;
    f_al_nxt     = f_al;
    f_dt_nxt     = f_dt;
    cnt_nxt      = cnt;
    cmd_op_nxt   = cmd_op;
    cmd_addr_nxt = cmd_addr;
    cmd_data_nxt = cmd_data;
    err_csum_nxt = 1'b0;
    err_tout_nxt = 1'b0;
    err_ovf_nxt  = 1'b0;
    // a handshake at this edge retires the pending command; a frame
    // completing in the same edge may overwrite this below
    cmd_vld_nxt  = cmd_vld & ~cmd_rdy;

    if (rx_data_vld) begin
      cnt_nxt = '0;
      case (state)
        IDLE: if (rx_data == HDR0) state_nxt = H1;
        H1: begin
          // a repeated HDR0 may be the real start of a frame: stay aligned
          if (rx_data == HDR1)      state_nxt = OP;
          else if (rx_data != HDR0) state_nxt = IDLE;
        end
        OP: begin
          f_op_nxt  = rx_data;
          acc_nxt   = rx_data;
          state_nxt = AH;
        end
        AH: begin
          f_ah_nxt  = rx_data;
          acc_nxt   = acc + rx_data;
          state_nxt = AL;
        end
        AL: begin
          f_al_nxt  = rx_data;
          acc_nxt   = acc + rx_data;
          state_nxt = DT;
        end
        DT: begin
          f_dt_nxt  = rx_data;
          acc_nxt   = acc + rx_data;
          state_nxt = CS;
        end
        CS: begin
          state_nxt = IDLE;
          if (rx_data != acc) begin
            err_csum_nxt = 1'b1;
          end else if (!cmd_vld || cmd_rdy) begin
            cmd_vld_nxt  = 1'b1;
            cmd_op_nxt   = f_op;
            cmd_addr_nxt = {f_ah, f_al};
            cmd_data_nxt = f_dt;
          end else begin
            err_ovf_nxt = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end else if (state == IDLE) begin
      cnt_nxt = '0;
    end else if (cnt == TO_LAST) begin
      cnt_nxt      = '0;
      state_nxt    = IDLE;
      err_tout_nxt = 1'b1;
    end else begin
      cnt_nxt = cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: directed frames from the test plan
// with literal expectations, then randomized byte traffic, gaps, backpressure
// and resets compared every cycle against a frame-buffer reference model.
module tb_uart_cmd_parser;
  localparam int TO = 100;

  logic        sclk = 1'b0;
  logic        s_rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_data_vld = 1'b0;
  logic        cmd_rdy = 1'b0;
  logic        cmd_vld;
  logic [7:0]  cmd_op, cmd_data;
  logic [15:0] cmd_addr;
  logic        err_csum, err_tout, err_ovf, busy;

  uart_cmd_parser #(.TIMEOUT_CYC(TO)) dut (
    .sclk(sclk), .s_rst(s_rst), .rx_data(rx_data), .rx_data_vld(rx_data_vld),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data), .err_csum(err_csum), .err_tout(err_tout),
    .err_ovf(err_ovf), .busy(busy)
  );

  always #5 sclk = ~sclk;

  int checks = 0;
  int failures = 0;
  bit run = 1'b0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  // Bytes of the frame collected so far; a frame is complete at 7 bytes.
  logic [7:0]  q[$];
  int          since = 0;      // edges since the last byte strobe
  logic        m_vld = 0, m_csum = 0, m_tout = 0, m_ovf = 0, m_busy = 0;
  logic [7:0]  m_op = 0, m_data = 0;
  logic [15:0] m_addr = 0;

  task automatic model_edge();
    logic [7:0] s;
    bit ld;
    if (s_rst) begin
      q.delete(); since = 0;
      m_vld = 0; m_op = 0; m_addr = 0; m_data = 0;
      m_csum = 0; m_tout = 0; m_ovf = 0; m_busy = 0;
      return;
    end
    m_csum = 0; m_tout = 0; m_ovf = 0; ld = 0;
    if (rx_data_vld) begin
      since = 0;
      if (q.size() == 0) begin
        if (rx_data == 8'h55) q.push_back(rx_data);
      end else if (q.size() == 1) begin
        if (rx_data == 8'hAA) q.push_back(rx_data);
        else if (rx_data != 8'h55) q.delete();
      end else begin
        q.push_back(rx_data);
      end
      if (q.size() == 7) begin
        s = 8'(q[2] + q[3] + q[4] + q[5]);
        if (s != q[6]) m_csum = 1;
        else if (!m_vld || cmd_rdy) ld = 1;
        else m_ovf = 1;
        if (ld) begin
          m_op = q[2]; m_addr = {q[3], q[4]}; m_data = q[5];
        end
        q.delete();
      end
    end else begin
      since++;
      if (q.size() != 0 && since == TO) begin
        m_tout = 1;
        q.delete();
      end
    end
    if (ld) m_vld = 1;
    else if (m_vld && cmd_rdy) m_vld = 0;
    m_busy = (q.size() != 0);
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge sclk) begin
    if (run) begin
      chk("cmd_vld", cmd_vld, m_vld);
      chk("busy", busy, m_busy);
      chk("err_csum", err_csum, m_csum);
      chk("err_tout", err_tout, m_tout);
      chk("err_ovf", err_ovf, m_ovf);
      if (m_vld) begin
        chk("cmd_op", cmd_op, m_op);
        chk("cmd_addr", cmd_addr, m_addr);
        chk("cmd_data", cmd_data, m_data);
      end
    end
  end

  // ---------------- stimulus ----------------
  // Drive inputs for one edge; returns at the following negedge.
  task automatic step(input bit v, input logic [7:0] b, input bit r, input bit rst);
    rx_data_vld = v; rx_data = b; cmd_rdy = r; s_rst = rst;
    @(posedge sclk);
    model_edge();
    @(negedge sclk);
  endtask

  task automatic send(input logic [7:0] f[$], input bit r);
    foreach (f[i]) step(1'b1, f[i], r, 1'b0);
  endtask

  task automatic idle(input int n, input bit r);
    repeat (n) step(1'b0, 8'(($urandom_range(0, 255))), r, 1'b0);
  endtask

  function automatic logic [7:0] rbyte();
    case ($urandom_range(0, 3))
      0: return 8'h55;
      1: return 8'hAA;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  function automatic bit rr(input int rb);
    return $urandom_range(0, 3) < rb;
  endfunction

  logic [7:0] fr[$];

  initial begin
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    run = 1'b1;
    chk("rst_vld", cmd_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_errs", {err_csum, err_tout, err_ovf}, 0);
    chk("rst_fields", {cmd_op, cmd_addr, cmd_data}, 0);

    // good frame
    fr = '{8'h55, 8'hAA, 8'h01, 8'h12, 8'h34, 8'h5A, 8'hA1};
    send(fr, 1);
    chk("good_vld", cmd_vld, 1);
    chk("good_op", cmd_op, 8'h01);
    chk("good_addr", cmd_addr, 16'h1234);
    chk("good_data", cmd_data, 8'h5A);
    chk("good_errs", {err_csum, err_tout, err_ovf}, 0);
    chk("model_good", {m_vld, m_op, m_addr, m_data}, {1'b1, 8'h01, 16'h1234, 8'h5A});
    step(0, 0, 1, 0);
    chk("good_drop", cmd_vld, 0);

    // bad checksum
    fr = '{8'h55, 8'hAA, 8'h01, 8'h12, 8'h34, 8'h5A, 8'hA2};
    send(fr, 1);
    chk("bad_csum", err_csum, 1);
    chk("bad_vld", cmd_vld, 0);
    chk("bad_busy", busy, 0);
    chk("model_bad", m_csum, 1);
    step(0, 0, 1, 0);
    chk("bad_pulse", err_csum, 0);

    // header resync and checksum wrap
    fr = '{8'h55, 8'h55, 8'hAA, 8'h80, 8'h80, 8'h80, 8'h80, 8'h00};
    send(fr, 1);
    chk("wrap_vld", cmd_vld, 1);
    chk("wrap_fields", {cmd_op, cmd_addr, cmd_data}, {8'h80, 16'h8080, 8'h80});
    step(0, 0, 1, 0);

    // timeout
    fr = '{8'h55, 8'hAA, 8'h01};
    send(fr, 1);
    chk("to_busy", busy, 1);
    idle(TO - 1, 1);
    chk("to_before", err_tout, 0);
    idle(1, 1);
    chk("to_pulse", err_tout, 1);
    chk("to_busy0", busy, 0);
    chk("model_to", m_tout, 1);
    fr = '{8'h55, 8'hAA, 8'h01, 8'h12, 8'h34, 8'h5A, 8'hA1};
    send(fr, 1);
    chk("to_recover", {cmd_vld, cmd_op}, {1'b1, 8'h01});
    step(0, 0, 1, 0);

    // byte arriving on the last allowed cycle wins over the timeout
    fr = '{8'h55, 8'hAA, 8'h01};
    send(fr, 1);
    idle(TO - 1, 1);
    fr = '{8'h12, 8'h34, 8'h5A, 8'hA1};
    send(fr, 1);
    chk("edge_vld", cmd_vld, 1);
    step(0, 0, 1, 0);

    // backpressure / overflow
    fr = '{8'h55, 8'hAA, 8'h01, 8'h12, 8'h34, 8'h5A, 8'hA1};
    send(fr, 0);
    chk("bp_vld", cmd_vld, 1);
    fr = '{8'h55, 8'hAA, 8'h02, 8'h12, 8'h34, 8'h5A, 8'hA2};
    send(fr, 0);
    chk("ovf_pulse", err_ovf, 1);
    chk("ovf_hold", {cmd_vld, cmd_op}, {1'b1, 8'h01});
    step(0, 0, 1, 0);
    chk("ovf_drop", cmd_vld, 0);

    // reset mid-frame with a pending command
    fr = '{8'h55, 8'hAA, 8'h01, 8'h12, 8'h34, 8'h5A, 8'hA1};
    send(fr, 0);
    fr = '{8'h55, 8'hAA, 8'h01, 8'h12};
    send(fr, 0);
    step(0, 0, 0, 1);
    chk("mrst_out", {cmd_vld, busy, err_csum, err_tout, err_ovf}, 0);
    chk("mrst_fields", {cmd_op, cmd_addr, cmd_data}, 0);
    fr = '{8'h34, 8'h5A, 8'hA1};
    send(fr, 1);
    chk("mrst_tail", {cmd_vld, err_csum, err_tout, err_ovf}, 0);

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      int kind, rb, nb, gj;
      logic [7:0] op, ah, al, dt, cs;
      kind = $urandom_range(0, 19);
      rb   = $urandom_range(0, 4);
      op = rbyte(); ah = rbyte(); al = rbyte(); dt = rbyte();
      cs = 8'(op + ah + al + dt);
      if (kind == 2) cs = 8'(cs + 8'($urandom_range(1, 255)));
      fr = '{8'h55, 8'hAA, op, ah, al, dt, cs};
      if ($urandom_range(0, 7) == 0) fr.push_front(8'h55);
      nb = fr.size();
      gj = -1;
      if (kind == 3) nb = $urandom_range(1, fr.size() - 1);
      if (kind == 4) gj = $urandom_range(2, fr.size() - 1);
      if (kind == 0) begin
        step(0, 0, rr(rb), 1);
      end else if (kind == 1) begin
        repeat ($urandom_range(1, 5)) step(1, rbyte(), rr(rb), 0);
      end else begin
        for (int i = 0; i < nb; i++) begin
          if (i == gj) idle(TO - 1 + $urandom_range(0, 1), rr(rb));
          else idle($urandom_range(0, 2), rr(rb));
          step(1, fr[i], rr(rb), 0);
        end
        if (kind == 3) idle(TO + $urandom_range(0, 1), rr(rb));
      end
    end
    idle(5, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
